// File: rtl/bnn_pkg.sv
// Shared types and helpers for the binarised layer engine and its memory models.
package bnn_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ACT   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Ceiling log2, usable in parameter expressions; clog2(1) == 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) r++;
        return r;
    endfunction

    localparam int DEF_LANES      = 8;
    localparam int DEF_W_ADDR_LEN = 20;
    localparam int DEF_X_ADDR_LEN = 10;

endpackage

// File: rtl/bnn_xnor_popcount.sv
// Combinational LANES-wide XNOR, lane mask and popcount.
module bnn_xnor_popcount
    import bnn_pkg::*;
#(
    parameter int  LANES = DEF_LANES,
    localparam int PW    = clog2(LANES + 1)
) (
    input  logic [LANES-1:0] i_w,
    input  logic [LANES-1:0] i_x,
    input  logic [LANES-1:0] i_mask,
    output logic [PW-1:0]    o_cnt
);

    logic [LANES-1:0] w_match;
    assign w_match = ~(i_w ^ i_x) & i_mask;

    // Count matching lanes that fall inside the mask.
    always_comb begin
        o_cnt = '0;
        for (int i = 0; i < LANES; i++) o_cnt = o_cnt + PW'(w_match[i]);
    end

endmodule

// File: rtl/bnn_layer_engine.sv
// One binarised layer: stream W/X words, XNOR-popcount per neuron,
// sign-activate, pack LANES bits per word and write back to a dst bank.
module bnn_layer_engine
    import bnn_pkg::*;
#(
    parameter int  LANES      = DEF_LANES,
    parameter int  N_IN_MAX   = 1024,
    parameter int  N_OUT_MAX  = 1024,
    parameter int  W_ADDR_LEN = DEF_W_ADDR_LEN,
    parameter int  X_ADDR_LEN = DEF_X_ADDR_LEN,
    parameter int  W_SEL_LEN  = 2,
    parameter int  X_SEL_LEN  = 2,
    localparam int CNT_W      = clog2(N_IN_MAX + 1),
    localparam int OUT_W      = clog2(N_OUT_MAX + 1),
    localparam int PW         = clog2(LANES + 1),
    localparam int LW         = (LANES > 1) ? clog2(LANES) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_start,
    input  logic [CNT_W-1:0]      i_cfg_n_in,
    input  logic [OUT_W-1:0]      i_cfg_n_out,
    input  logic [W_ADDR_LEN-1:0] i_cfg_w_base,
    input  logic [W_SEL_LEN-1:0]  i_cfg_w_sel,
    input  logic [X_SEL_LEN-1:0]  i_cfg_src_sel,
    input  logic [X_SEL_LEN-1:0]  i_cfg_dst_sel,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [W_ADDR_LEN-1:0] o_w_addr,
    output logic [W_SEL_LEN-1:0]  o_w_sel,
    output logic                  o_w_rq,
    input  logic [LANES-1:0]      i_w_data,
    output logic [X_ADDR_LEN-1:0] o_x_addr,
    output logic [X_SEL_LEN-1:0]  o_x_sel,
    output logic                  o_x_rq,
    input  logic [LANES-1:0]      i_x_data,
    output logic                  o_x_wq,
    output logic [LANES-1:0]      o_wx_write
);

    state_e                r_state, w_next;
    logic [CNT_W-1:0]      r_n_in, r_words, r_k, r_acc;
    logic [OUT_W-1:0]      r_n_out, r_j;
    logic [W_ADDR_LEN-1:0] r_wptr;
    logic [W_SEL_LEN-1:0]  r_w_sel;
    logic [X_SEL_LEN-1:0]  r_src, r_dst;
    logic [LANES-1:0]      r_mask, r_pack;
    logic                  r_err;

    logic [CNT_W-1:0]      w_words, w_acc_fin;
    logic [LW-1:0]         w_rem, w_lane;
    logic [LANES-1:0]      w_mask, w_pmask;
    logic [PW-1:0]         w_cnt;
    logic                  w_reject, w_last_k, w_last_j, w_word_full, w_bit;

    assign w_words  = CNT_W'(({1'b0, i_cfg_n_in} + (CNT_W+1)'(LANES - 1)) / (CNT_W+1)'(LANES));
    assign w_rem    = LW'(i_cfg_n_in % CNT_W'(LANES));
    assign w_reject = (i_cfg_n_in == '0) || (i_cfg_n_out == '0) ||
                      (i_cfg_n_in > CNT_W'(N_IN_MAX)) || (i_cfg_n_out > OUT_W'(N_OUT_MAX)) ||
                      (i_cfg_src_sel == i_cfg_dst_sel);

    // Last-word lane mask: a zero remainder means the last word is full.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < LANES; i++) w_mask[i] = (w_rem == '0) || (LW'(i) < w_rem);
    end

    assign w_last_k    = (r_k == r_words - CNT_W'(1));
    assign w_last_j    = (r_j == r_n_out - OUT_W'(1));
    assign w_lane      = LW'(r_j % OUT_W'(LANES));
    assign w_word_full = (w_lane == LW'(LANES - 1));
    // Only the word consumed in ACT is the last one of a neuron.
    assign w_pmask     = (r_state == S_ACT) ? r_mask : '1;

    bnn_xnor_popcount #(.LANES(LANES)) u_pop (
        .i_w    (i_w_data),
        .i_x    (i_x_data),
        .i_mask (w_pmask),
        .o_cnt  (w_cnt)
    );

    assign w_acc_fin = r_acc + CNT_W'(w_cnt);
    // Sign activation with ties firing: 2*acc >= n_in, one extra bit of headroom.
    assign w_bit     = ({w_acc_fin, 1'b0} >= {1'b0, r_n_in});

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; en low always returns to IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = w_reject ? S_DONE : S_FETCH;
            S_FETCH: if (w_last_k) w_next = S_ACT;
            S_ACT:   w_next = (w_word_full || w_last_j) ? S_WRITE : S_FETCH;
            S_WRITE: w_next = w_last_j ? S_DONE : S_FETCH;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (!i_en) w_next = S_IDLE;
    end

    // Outputs decoded from state; strobes are additionally gated by en.
    always_comb begin
        o_busy     = 1'b0;
        o_done     = 1'b0;
        o_err      = 1'b0;
        o_w_addr   = '0;
        o_w_sel    = '0;
        o_w_rq     = 1'b0;
        o_x_addr   = '0;
        o_x_sel    = '0;
        o_x_rq     = 1'b0;
        o_x_wq     = 1'b0;
        o_wx_write = '0;
        case (r_state)
            S_FETCH: begin
                o_busy   = 1'b1;
                o_w_rq   = i_en;
                o_x_rq   = i_en;
                o_w_addr = r_wptr;
                o_w_sel  = r_w_sel;
                o_x_addr = X_ADDR_LEN'(r_k);
                o_x_sel  = r_src;
            end
            S_ACT:   o_busy = 1'b1;
            S_WRITE: begin
                o_busy     = 1'b1;
                o_x_wq     = i_en;
                o_x_addr   = X_ADDR_LEN'(r_j / OUT_W'(LANES));
                o_x_sel    = r_dst;
                o_wx_write = r_pack;
            end
            S_DONE: begin
                o_done = i_en;
                o_err  = i_en & r_err;
            end
            default: ;
        endcase
    end

    // Datapath: config latch, word/neuron counters, weight pointer, acc and pack.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_n_in  <= '0;
            r_n_out <= '0;
            r_words <= '0;
            r_mask  <= '0;
            r_wptr  <= '0;
            r_w_sel <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_err   <= 1'b0;
            r_k     <= '0;
            r_j     <= '0;
            r_acc   <= '0;
            r_pack  <= '0;
        end else if (!i_en) begin
            r_k    <= '0;
            r_j    <= '0;
            r_acc  <= '0;
            r_pack <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_n_in  <= i_cfg_n_in;
                    r_n_out <= i_cfg_n_out;
                    r_words <= w_words;
                    r_mask  <= w_mask;
                    r_wptr  <= i_cfg_w_base;
                    r_w_sel <= i_cfg_w_sel;
                    r_src   <= i_cfg_src_sel;
                    r_dst   <= i_cfg_dst_sel;
                    r_err   <= w_reject;
                    r_k     <= '0;
                    r_j     <= '0;
                    r_acc   <= '0;
                    r_pack  <= '0;
                end
                S_FETCH: begin
                    // Word k-1 returns while word k is requested.
                    r_wptr <= r_wptr + W_ADDR_LEN'(1);
                    if (r_k != '0) r_acc <= w_acc_fin;
                    r_k <= w_last_k ? '0 : r_k + CNT_W'(1);
                end
                S_ACT: begin
                    r_pack[w_lane] <= w_bit;
                    r_acc          <= '0;
                    if (!(w_word_full || w_last_j)) r_j <= r_j + OUT_W'(1);
                end
                S_WRITE: begin
                    r_pack <= '0;
                    if (!w_last_j) r_j <= r_j + OUT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bnn_layer_engine.md
Name: bnn_layer_engine

Overview:
- Parametrised successor to the single-bit XNOR/popcount layer sequencer; one invocation evaluates one full binarised layer.
- Streams LANES-wide weight and activation words from the W and X memories and accumulates XNOR popcounts per neuron.
- Applies a sign activation, packs the output bits into LANES-wide words and writes them back to a selectable X bank.
- Multi-layer networks are sequenced by an external controller that issues one start per layer, ping-ponging src/dst banks.

Parameters:
- LANES, 8, bits per memory word and XNOR lanes evaluated per cycle.
- N_IN_MAX, 1024, largest supported layer fan-in.
- N_OUT_MAX, 1024, largest supported neuron count.
- W_ADDR_LEN, 20, weight word address width.
- X_ADDR_LEN, 10, activation word address width.
- W_SEL_LEN, 2, weight bank select width.
- X_SEL_LEN, 2, activation bank select width.
- CNT_W, clog2(N_IN_MAX+1), accumulator and fan-in config width (localparam).
- OUT_W, clog2(N_OUT_MAX+1), neuron counter and fan-out config width (localparam).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  synchronous enable; 0 aborts the run and returns to IDLE.
- start  in  1  one-cycle request; sampled only in IDLE.
- cfg_n_in  in  CNT_W  layer fan-in in bits.
- cfg_n_out  in  OUT_W  neuron count.
- cfg_w_base  in  W_ADDR_LEN  first weight word address.
- cfg_w_sel  in  W_SEL_LEN  weight bank.
- cfg_src_sel  in  X_SEL_LEN  activation source bank.
- cfg_dst_sel  in  X_SEL_LEN  activation destination bank.
- busy  out  1  run in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 when the run was rejected.
- w_addr  out  W_ADDR_LEN  weight read address.
- w_sel  out  W_SEL_LEN  weight bank select.
- w_rq  out  1  weight read request.
- w_data  in  LANES  weight word; valid 1 cycle after w_rq.
- x_addr  out  X_ADDR_LEN  activation address, shared by read and write.
- x_sel  out  X_SEL_LEN  activation bank select.
- x_rq  out  1  activation read request.
- x_data  in  LANES  activation word; valid 1 cycle after x_rq.
- x_wq  out  1  activation write strobe.
- wx_write  out  LANES  packed output word; valid with x_wq.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; all counters, the accumulator and the pack register cleared.
- IDLE + start: latch all cfg_* inputs; later cfg changes are ignored until the next start. Compute WORDS = ceil(n_in/LANES).
- Reject on start when n_in==0, n_out==0, n_in>N_IN_MAX, n_out>N_OUT_MAX, or src_sel==dst_sel: no memory access; done=1 and err=1 in the next cycle; busy stays 0.
- States: IDLE -> FETCH -> ACT -> (WRITE) -> FETCH ... -> DONE -> IDLE.
- FETCH: one read per cycle for k = 0..WORDS-1.
  - x_rq=w_rq=1, x_addr=k, x_sel=src_sel, w_sel=w_sel.
  - w_addr = w_base + j*WORDS + k, produced by a running pointer (no multiplier).
  - The data for request k returns in the following cycle and is accumulated then: acc += popcount(~(w_data ^ x_data) & mask).
- Mask: all ones except on the last word, where lanes >= n_in - (WORDS-1)*LANES are 0. Padded lanes never count.
- ACT: accumulate the last word; bit = (2*acc >= n_in); write bit into pack[j mod LANES]; clear acc. No requests in this state.
- ACT -> WRITE when j mod LANES == LANES-1 or j == n_out-1; otherwise ACT -> FETCH with j+1.
- WRITE, one cycle:
  - x_wq=1, x_sel=dst_sel, x_addr=j/LANES, wx_write=pack.
  - Unfilled upper bits of a final partial word are 0.
  - Clear pack afterwards.
- WRITE -> DONE after the last neuron; otherwise -> FETCH.
- Requests and the write strobe are mutually exclusive; x_rq and x_wq are never 1 in the same cycle.
- Timing: busy is 1 from the cycle after start for exactly n_out*(WORDS+1) + ceil(n_out/LANES) cycles. DONE then pulses done=1, err=0, busy=0 for one cycle.
- en=0 in any state: next cycle is IDLE; requests and strobes drop; acc and pack are cleared; no done pulse. en=0 also blocks start.
- start while busy or in DONE: ignored.
- Async reset mid-run: immediate return to the reset state, with no further memory traffic.
- Widths: acc is CNT_W bits and cannot overflow because acc <= n_in <= N_IN_MAX. The comparison uses CNT_W+1 bits.

Decomposition:
- Shared package bnn_pkg holds:
  - FSM state encoding: IDLE, FETCH, ACT, WRITE, DONE.
  - The clog2 function.
  - Default LANES and address widths used by the memory models.
- One sub-module, bnn_xnor_popcount: combinational LANES-wide XNOR + mask + popcount, output width clog2(LANES+1).

Test Plan:
- LANES=8, n_in=16, n_out=8, all weight and activation words 0xFF -> 8 neurons each fire; one write of 0xFF to x_addr 0 on dst; busy lasts 8*3+1=25 cycles; done=1, err=0.
- n_in=12, n_out=3, weights 0x00, activations 0xFF, plus garbage in the upper nibble of the last word -> acc=0 for every neuron; write 0x00; the masked lanes are proven ignored by injecting 0x0F/0xF0 patterns.
- n_in=10, n_out=10, alternate neurons with weights equal to x and weights equal to ~x -> written words 0x55 at addr 0 and 0x01 at addr 1; w_addr increments contiguously from w_base.
- Tie case: n_in=8, exactly 4 matching lanes -> bit=1 (2*4>=8); 3 matching lanes -> bit=0.
- start with src_sel==dst_sel, or with n_out=0 -> done=1 and err=1 one cycle later, no rq/wq asserted.
- Drive en=0 at the 5th FETCH cycle, and separately assert rst low mid-WRITE -> all strobes drop, no done pulse; a new start then completes normally with correct results.
